// File: rtl/eeg_pea_omux_pkg.sv
// Shared types and sizing helpers for the PE-array output collector.
package eeg_pea_omux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIN
  } omux_state_e;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned OMUX_PE_NUM = 16;
  localparam int unsigned OMUX_IDX_W  = idx_w(OMUX_PE_NUM);

endpackage

// File: rtl/eeg_pea_omux_rrarb.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping circularly.
module eeg_pea_omux_rrarb #(
  parameter int unsigned N = 16,
  parameter int unsigned W = 4
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx
);

  always_comb begin : scan
    int unsigned j;
    logic [W-1:0] jj;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    j       = 0;
    jj      = '0;
    for (int unsigned i = 0; i < N; i++) begin
      j = 32'(ptr) + i;
      if (j >= N) j = j - N;
      jj = W'(j);
      if (!found && req[jj]) begin
        found   = 1'b1;
        gnt[jj] = 1'b1;
        gnt_idx = jj;
      end
    end
  end

endmodule

// File: rtl/eeg_pea_omux.sv
// PE-array output collector: arbitrates PE output streams into registered ORAM writes
// and signals completion once every PE has delivered its last beat.
module eeg_pea_omux
  import eeg_pea_omux_pkg::*;
#(
  parameter int unsigned PE_ROW      = 4,
  parameter int unsigned PE_COL      = 4,
  parameter int unsigned DATA_OUT_DW = 8,
  parameter int unsigned OMUX_ADD_AW = 8,
  parameter int unsigned ORAM_ADD_AW = 10
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           CFG_START,
  input  logic [ORAM_ADD_AW-1:0]                         CFG_ORAM_BASE,
  input  logic [ORAM_ADD_AW-1:0]                         CFG_ORAM_PLEN,
  output logic                                           IS_IDLE,
  output logic                                           DONE,
  output logic                                           ERR,
  input  logic [PE_COL-1:0][PE_ROW-1:0]                  OUT_VLD,
  input  logic [PE_COL-1:0][PE_ROW-1:0]                  OUT_LST,
  output logic [PE_COL-1:0][PE_ROW-1:0]                  OUT_RDY,
  input  logic [PE_COL-1:0][PE_ROW-1:0][DATA_OUT_DW-1:0] OUT_DAT,
  input  logic [PE_COL-1:0][PE_ROW-1:0][OMUX_ADD_AW-1:0] OUT_ADD,
  output logic                                           ORAM_WEN,
  output logic [ORAM_ADD_AW-1:0]                         ORAM_ADD,
  output logic [DATA_OUT_DW-1:0]                         ORAM_DAT,
  input  logic                                           ORAM_RDY
);

  localparam int unsigned PE_NUM = PE_COL * PE_ROW;
  localparam int unsigned KW     = idx_w(PE_NUM);

  // Packed [col][row] flattens to bit index col*PE_ROW+row, i.e. stream index k.
  logic [PE_NUM-1:0]             vld_flat, lst_flat, req, gnt;
  logic [PE_NUM*DATA_OUT_DW-1:0] dat_flat;
  logic [PE_NUM*OMUX_ADD_AW-1:0] add_flat;
  logic [KW-1:0]                 gnt_idx;

  assign vld_flat = OUT_VLD;
  assign lst_flat = OUT_LST;
  assign dat_flat = OUT_DAT;
  assign add_flat = OUT_ADD;
  assign OUT_RDY  = gnt;

  omux_state_e             state_q, state_d;
  logic [KW-1:0]           ptr_q, ptr_d;
  logic [PE_NUM-1:0]       lst_seen_q, lst_seen_d;
  logic [ORAM_ADD_AW-1:0]  base_q, base_d, plen_q, plen_d;
  logic                    wen_q, wen_d;
  logic [ORAM_ADD_AW-1:0]  add_q, add_d;
  logic [DATA_OUT_DW-1:0]  dat_q, dat_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic                    arb_open, accept, sel_lst, seen_hit;
  logic [DATA_OUT_DW-1:0]  sel_dat;
  logic [OMUX_ADD_AW-1:0]  sel_add;
  logic [ORAM_ADD_AW-1:0]  k_ext, oram_add_nxt;

  // The output register may take a new beat only if it is empty or drains this cycle.
  assign arb_open = (state_q == ST_RUN) && (!wen_q || ORAM_RDY);
  assign req      = arb_open ? vld_flat : '0;
  assign accept   = |gnt;

  eeg_pea_omux_rrarb #(
    .N (PE_NUM),
    .W (KW)
  ) u_rrarb (
    .req     (req),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    sel_dat = '0;
    sel_add = '0;
    for (int unsigned k = 0; k < PE_NUM; k++) begin
      if (gnt[k]) begin
        sel_dat = sel_dat | dat_flat[k*DATA_OUT_DW +: DATA_OUT_DW];
        sel_add = sel_add | add_flat[k*OMUX_ADD_AW +: OMUX_ADD_AW];
      end
    end
    sel_lst      = |(lst_flat & gnt);
    seen_hit     = |(lst_seen_q & gnt);
    k_ext        = ORAM_ADD_AW'(gnt_idx);
    oram_add_nxt = base_q + (k_ext * plen_q) + ORAM_ADD_AW'(sel_add);
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    lst_seen_d = lst_seen_q;
    base_d     = base_q;
    plen_d     = plen_q;
    wen_d      = wen_q;
    add_d      = add_q;
    dat_d      = dat_q;
    done_d     = 1'b0;
    err_d      = err_q;

    if (accept) begin
      wen_d      = 1'b1;
      add_d      = oram_add_nxt;
      dat_d      = sel_dat;
      ptr_d      = (gnt_idx == KW'(PE_NUM - 1)) ? '0 : gnt_idx + 1'b1;
      lst_seen_d = lst_seen_q | (gnt & {PE_NUM{sel_lst}});
      if (seen_hit) err_d = 1'b1;
    end else if (ORAM_RDY) begin
      wen_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (CFG_START) begin
          state_d    = ST_RUN;
          base_d     = CFG_ORAM_BASE;
          plen_d     = CFG_ORAM_PLEN;
          lst_seen_d = '0;
        end
      end
      ST_RUN: begin
        if (&lst_seen_d) state_d = ST_FIN;
      end
      ST_FIN: begin
        if (!wen_q || ORAM_RDY) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      lst_seen_q <= '0;
      base_q     <= '0;
      plen_q     <= '0;
      wen_q      <= 1'b0;
      add_q      <= '0;
      dat_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      lst_seen_q <= lst_seen_d;
      base_q     <= base_d;
      plen_q     <= plen_d;
      wen_q      <= wen_d;
      add_q      <= add_d;
      dat_q      <= dat_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign IS_IDLE  = (state_q == ST_IDLE);
  assign DONE     = done_q;
  assign ERR      = err_q;
  assign ORAM_WEN = wen_q;
  assign ORAM_ADD = add_q;
  assign ORAM_DAT = dat_q;

endmodule
